// File: rtl/parser_cfg_loader_if.sv
// Control AXI-Stream bundle used on both sides of the parser config loader.
// Master drives the beat, slave observes it; there is no backpressure (no tready).
interface parser_cfg_loader_if #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned USER_W = 128
) ();

    logic [DATA_W-1:0]   tdata;
    logic [USER_W-1:0]   tuser;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tlast;

    modport master (
        output tdata,
        output tuser,
        output tkeep,
        output tvalid,
        output tlast
    );

    modport slave (
        input tdata,
        input tuser,
        input tkeep,
        input tvalid,
        input tlast
    );

endinterface

// File: rtl/parser_cfg_loader.sv
// Claims control packets addressed to this parser's action table and writes their payload
// beats to consecutive action-RAM entries; every other control packet is forwarded unchanged.
module parser_cfg_loader #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned PARSE_ACT_RAM_WIDTH  = 167,
    parameter logic [3:0]  PARSER_ID            = 4'd0,
    parameter logic [3:0]  RESOURCE_ID          = 4'd2,
    parameter int unsigned NUM_ENTRIES          = 32,
    parameter int unsigned ADDR_W               = 5
) (
    input  logic                           axis_clk,
    input  logic                           areset,

    parser_cfg_loader_if.slave             c_s_axis,
    parser_cfg_loader_if.master            c_m_axis,

    output logic                           ram_wr_en,
    output logic [ADDR_W-1:0]              ram_wr_addr,
    output logic [PARSE_ACT_RAM_WIDTH-1:0] ram_wr_data,

    output logic                           cfg_done,
    output logic                           cfg_err,
    output logic [15:0]                    cfg_pkt_cnt
);

    localparam int unsigned W      = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned KeepW  = W / 8;
    localparam int unsigned ModLsb = W - 132;
    localparam int unsigned ResLsb = W - 136;
    localparam int unsigned IdxLsb = W - 141;
    // Wide enough for 0..32 so the pointer can park one past the last entry.
    localparam int unsigned PtrW   = 6;

    localparam logic [PtrW-1:0] NumEntries = PtrW'(NUM_ENTRIES);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWrite   = 2'd1,
        StFwd     = 2'd2,
        StDropHdr = 2'd3
    } state_e;

    state_e                         state_q;
    logic [PtrW-1:0]                wr_ptr_q;

    logic [W-1:0]                   fwd_data_q;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] fwd_user_q;
    logic [KeepW-1:0]               fwd_keep_q;
    logic                           fwd_valid_q;
    logic                           fwd_last_q;

    logic                           wr_en_q;
    logic [ADDR_W-1:0]              wr_addr_q;
    logic [PARSE_ACT_RAM_WIDTH-1:0] wr_data_q;

    logic                           done_q;
    logic                           err_q;
    logic [15:0]                    pkt_cnt_q;

    logic [3:0]      hdr_mod;
    logic [3:0]      hdr_res;
    logic [4:0]      hdr_idx;
    logic            hdr_claim;
    logic            ptr_in_range;
    logic [PtrW-1:0] ptr_next;

    always_comb begin
        hdr_mod      = c_s_axis.tdata[ModLsb +: 4];
        hdr_res      = c_s_axis.tdata[ResLsb +: 4];
        hdr_idx      = c_s_axis.tdata[IdxLsb +: 5];
        hdr_claim    = (hdr_mod == PARSER_ID) && (hdr_res == RESOURCE_ID);
        ptr_in_range = (wr_ptr_q < NumEntries);
        // Saturate at the table depth so an overrun never wraps back onto live entries.
        ptr_next     = ptr_in_range ? (wr_ptr_q + PtrW'(1)) : NumEntries;
    end

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            fwd_data_q  <= '0;
            fwd_user_q  <= '0;
            fwd_keep_q  <= '0;
            fwd_valid_q <= 1'b0;
            fwd_last_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            fwd_data_q  <= '0;
            fwd_user_q  <= '0;
            fwd_keep_q  <= '0;
            fwd_valid_q <= 1'b0;
            fwd_last_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;

            if (c_s_axis.tvalid) begin
                unique case (state_q)
                    StIdle: begin
                        if (hdr_claim) begin
                            if (c_s_axis.tlast) begin
                                done_q    <= 1'b1;
                                pkt_cnt_q <= pkt_cnt_q + 16'd1;
                            end else begin
                                wr_ptr_q <= PtrW'(hdr_idx);
                                state_q  <= StWrite;
                            end
                        end else begin
                            fwd_data_q  <= c_s_axis.tdata;
                            fwd_user_q  <= c_s_axis.tuser;
                            fwd_keep_q  <= c_s_axis.tkeep;
                            fwd_valid_q <= 1'b1;
                            fwd_last_q  <= c_s_axis.tlast;
                            if (!c_s_axis.tlast) begin
                                state_q <= StFwd;
                            end
                        end
                    end

                    StWrite: begin
                        if (ptr_in_range) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= wr_ptr_q[ADDR_W-1:0];
                            wr_data_q <= c_s_axis.tdata[PARSE_ACT_RAM_WIDTH-1:0];
                        end else begin
                            err_q <= 1'b1;
                        end
                        wr_ptr_q <= ptr_next;
                        if (c_s_axis.tlast) begin
                            done_q    <= 1'b1;
                            pkt_cnt_q <= pkt_cnt_q + 16'd1;
                            state_q   <= StIdle;
                        end
                    end

                    StFwd: begin
                        fwd_data_q  <= c_s_axis.tdata;
                        fwd_user_q  <= c_s_axis.tuser;
                        fwd_keep_q  <= c_s_axis.tkeep;
                        fwd_valid_q <= 1'b1;
                        fwd_last_q  <= c_s_axis.tlast;
                        if (c_s_axis.tlast) begin
                            state_q <= StIdle;
                        end
                    end

                    // Reserved encoding: recover to header decode.
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign c_m_axis.tdata  = fwd_data_q;
    assign c_m_axis.tuser  = fwd_user_q;
    assign c_m_axis.tkeep  = fwd_keep_q;
    assign c_m_axis.tvalid = fwd_valid_q;
    assign c_m_axis.tlast  = fwd_last_q;

    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;

    assign cfg_done    = done_q;
    assign cfg_err     = err_q;
    assign cfg_pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_parser_cfg_loader.sv
// Randomized scoreboard bench for parser_cfg_loader: a packet-level model queues expected
// RAM writes, forwarded beats and completion records; a monitor pops them as the DUT emits.
module tb_parser_cfg_loader;

    localparam int unsigned W   = 512;
    localparam int unsigned TU  = 128;
    localparam int unsigned RW  = 167;
    localparam int unsigned NUM = 32;
    localparam int unsigned AW  = 5;
    localparam logic [3:0]  PID = 4'd1;
    localparam logic [3:0]  RID = 4'd2;

    typedef struct {
        logic [W-1:0]   data;
        logic [TU-1:0]  user;
        logic [W/8-1:0] keep;
        logic           last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] cnt;
        logic        err;
    } done_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parser_cfg_loader_if #(.DATA_W(W), .USER_W(TU)) s_if ();
    parser_cfg_loader_if #(.DATA_W(W), .USER_W(TU)) m_if ();

    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [RW-1:0] ram_wr_data;
    logic          cfg_done;
    logic          cfg_err;
    logic [15:0]   cfg_pkt_cnt;

    parser_cfg_loader #(
        .C_S_AXIS_DATA_WIDTH  (W),
        .C_S_AXIS_TUSER_WIDTH (TU),
        .PARSE_ACT_RAM_WIDTH  (RW),
        .PARSER_ID            (PID),
        .RESOURCE_ID          (RID),
        .NUM_ENTRIES          (NUM),
        .ADDR_W               (AW)
    ) dut (
        .axis_clk    (clk),
        .areset      (rst),
        .c_s_axis    (s_if),
        .c_m_axis    (m_if),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .cfg_pkt_cnt (cfg_pkt_cnt)
    );

    wr_t   wr_q[$];
    beat_t fwd_q[$];
    done_t done_q[$];
    int    m_cnt;
    bit    m_err;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT output present, scoreboard empty (t=%0t)", name, $time);
    endtask

    // Monitor: samples on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_wr_en) begin
                if (wr_q.size() == 0) begin
                    unexpected("ram_write");
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", W'(ram_wr_addr), W'(e.addr));
                    check("wr_data", W'(ram_wr_data), W'(e.data));
                end
            end
            if (m_if.tvalid) begin
                if (fwd_q.size() == 0) begin
                    unexpected("fwd_beat");
                end else begin
                    beat_t b;
                    b = fwd_q.pop_front();
                    check("fwd_tdata", m_if.tdata, b.data);
                    check("fwd_tuser", W'(m_if.tuser), W'(b.user));
                    check("fwd_tkeep", W'(m_if.tkeep), W'(b.keep));
                    check("fwd_tlast", W'(m_if.tlast), W'(b.last));
                end
            end else begin
                check("idle_tdata", m_if.tdata, '0);
            end
            if (cfg_done) begin
                if (done_q.size() == 0) begin
                    unexpected("cfg_done");
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("done_pkt_cnt", W'(cfg_pkt_cnt), W'(d.cnt));
                    check("done_err", W'(cfg_err), W'(d.err));
                end
            end
        end
    end

    function automatic beat_t rand_beat();
        beat_t b;
        for (int k = 0; k < W / 32; k++) b.data[k*32 +: 32] = $urandom;
        for (int k = 0; k < TU / 32; k++) b.user[k*32 +: 32] = $urandom;
        b.keep = {$urandom, $urandom};
        b.last = 1'b0;
        return b;
    endfunction

    task automatic drive(input logic valid, input beat_t b);
        @(posedge clk);
        #1;
        s_if.tvalid = valid;
        s_if.tdata  = b.data;
        s_if.tuser  = b.user;
        s_if.tkeep  = b.keep;
        s_if.tlast  = b.last;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b      = rand_beat();
            b.last = 1'($urandom);
            drive(1'b0, b);
        end
    endtask

    task automatic build_pkt(output beat_t pkt[$], input logic [3:0] mod, input logic [3:0] res,
                             input logic [4:0] idx, input int n);
        pkt = {};
        for (int k = 0; k < n; k++) pkt.push_back(rand_beat());
        pkt[0].data[W-129 -: 4] = mod;
        pkt[0].data[W-133 -: 4] = res;
        pkt[0].data[W-137 -: 5] = idx;
    endtask

    // Drives a packet and records what the specification says must come out of it.
    task automatic send_pkt(input beat_t pkt[$], input int gap_pct, input bit with_last);
        bit claimed;
        int idx;
        claimed = (pkt[0].data[W-129 -: 4] == PID) && (pkt[0].data[W-133 -: 4] == RID);
        idx     = int'(pkt[0].data[W-137 -: 5]);
        for (int i = 0; i < pkt.size(); i++) begin
            beat_t b;
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) idle(1);
            b      = pkt[i];
            b.last = with_last && (i == pkt.size() - 1);
            drive(1'b1, b);
            if (claimed) begin
                if (i > 0) begin
                    int a;
                    a = idx + i - 1;
                    if (a < NUM) wr_q.push_back('{addr: AW'(a), data: b.data[RW-1:0]});
                    else m_err = 1'b1;
                end
                if (b.last) begin
                    m_cnt = (m_cnt + 1) % 65536;
                    done_q.push_back('{cnt: 16'(m_cnt), err: m_err});
                end
            end else begin
                fwd_q.push_back(b);
            end
        end
    endtask

    task automatic drain_check(input string tag);
        idle(3);
        check({tag, "_wr_q_empty"}, W'(wr_q.size()), '0);
        check({tag, "_fwd_q_empty"}, W'(fwd_q.size()), '0);
        check({tag, "_done_q_empty"}, W'(done_q.size()), '0);
    endtask

    // Holds reset with a valid beat on the input, then checks every output is zero.
    task automatic do_reset();
        beat_t b;
        b = rand_beat();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = b.data;
        s_if.tuser  = b.user;
        s_if.tkeep  = b.keep;
        s_if.tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_tvalid", W'(m_if.tvalid), '0);
        check("rst_m_tdata", m_if.tdata, '0);
        check("rst_m_tuser", W'(m_if.tuser), '0);
        check("rst_m_tkeep", W'(m_if.tkeep), '0);
        check("rst_m_tlast", W'(m_if.tlast), '0);
        check("rst_wr_en", W'(ram_wr_en), '0);
        check("rst_wr_addr", W'(ram_wr_addr), '0);
        check("rst_wr_data", W'(ram_wr_data), '0);
        check("rst_done", W'(cfg_done), '0);
        check("rst_err", W'(cfg_err), '0);
        check("rst_pkt_cnt", W'(cfg_pkt_cnt), '0);
        rst         = 1'b0;
        s_if.tvalid = 1'b0;
        m_cnt       = 0;
        m_err       = 1'b0;
    endtask

    task automatic rand_pkt(input int kind);
        beat_t p[$];
        logic [3:0] mod;
        logic [3:0] res;
        mod = PID;
        res = RID;
        if (kind == 1) begin
            while (mod == PID) mod = 4'($urandom);
            res = 4'($urandom);
        end else if (kind == 2) begin
            while (res == RID) res = 4'($urandom);
        end
        build_pkt(p, mod, res, 5'($urandom), $urandom_range(1, 6));
        send_pkt(p, $urandom_range(0, 30), 1'b1);
    endtask

    initial begin
        beat_t p[$];
        rst         = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_cnt       = 0;
        m_err       = 1'b0;
        do_reset();

        // Claimed 4-beat burst at index 0.
        build_pkt(p, PID, RID, 5'd0, 4);
        p[1].data[17:0] = 18'h0ffff;
        p[2].data[31:0] = 32'h0eee_0ffff;
        p[3].data[31:0] = 32'h0eee_0ffff;
        send_pkt(p, 0, 1'b1);
        idle(2);
        check("burst_pkt_cnt", W'(cfg_pkt_cnt), W'(m_cnt));

        // Same packet, foreign module id.
        p[0].data[W-129 -: 4] = 4'd3;
        send_pkt(p, 0, 1'b1);
        idle(2);
        check("foreign_pkt_cnt", W'(cfg_pkt_cnt), W'(m_cnt));
        check("err_before_overrun", W'(cfg_err), '0);

        // Overrun: index 30 with four payload beats.
        build_pkt(p, PID, RID, 5'd30, 5);
        send_pkt(p, 0, 1'b1);
        idle(2);
        check("err_after_overrun", W'(cfg_err), W'(1));

        // Header-only claimed packet.
        build_pkt(p, PID, RID, 5'($urandom), 1);
        send_pkt(p, 0, 1'b1);

        // Back-to-back claimed then foreign, with gaps mid-packet.
        build_pkt(p, PID, RID, 5'd4, 6);
        send_pkt(p, 50, 1'b1);
        build_pkt(p, 4'd7, RID, 5'd4, 5);
        send_pkt(p, 50, 1'b1);

        for (int n = 0; n < 40; n++) rand_pkt($urandom_range(0, 2));
        drain_check("random");

        do_reset();
        for (int n = 0; n < 20; n++) rand_pkt(0);
        idle(2);
        check("cnt_after_20", W'(cfg_pkt_cnt), W'(20));

        // Leave a claimed packet open, then reset mid-packet.
        build_pkt(p, PID, RID, 5'd10, 3);
        send_pkt(p, 0, 1'b0);
        drain_check("pre_reset");
        do_reset();

        // First valid beat after reset must decode as a header.
        build_pkt(p, 4'd9, 4'd9, 5'd0, 3);
        send_pkt(p, 0, 1'b1);
        build_pkt(p, PID, RID, 5'd5, 3);
        send_pkt(p, 20, 1'b1);
        idle(2);
        check("cnt_after_reset", W'(cfg_pkt_cnt), W'(1));
        drain_check("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parser_cfg_loader.md
# parser_cfg_loader

Control-path configuration loader for the packet parser. Sits on the control AXI-Stream chain ahead of a parser instance. It claims configuration packets addressed to its parser ID and resource ID, and writes their payload beats as consecutive parse-action RAM entries. All other control packets pass downstream unchanged. It generalises the single-entry action-table write to multi-beat, multi-entry bursts with bounds checking and status reporting.

## Interface
Parameters:
- C_S_AXIS_DATA_WIDTH, 512, control AXIS data width; must be at least 256.
- C_S_AXIS_TUSER_WIDTH, 128, control AXIS tuser width.
- PARSE_ACT_RAM_WIDTH, 167, width of one action entry; must not exceed C_S_AXIS_DATA_WIDTH.
- PARSER_ID, 0, 4-bit module ID this instance answers to.
- RESOURCE_ID, 2, 4-bit resource ID of the action table.
- NUM_ENTRIES, 32, table depth; at most 32.
- ADDR_W, 5, RAM address width, equal to clog2(NUM_ENTRIES).

Ports:
- axis_clk  in  1  sole clock.
- areset  in  1  synchronous, active-high reset.
- c_s_axis_tdata/tuser/tkeep/tvalid/tlast  in  W/TU/W/8/1/1  control stream input; no backpressure.
- c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  W/TU/W/8/1/1  forwarded control stream.
- ram_wr_en  out  1  action RAM write strobe.
- ram_wr_addr  out  ADDR_W  write address.
- ram_wr_data  out  PARSE_ACT_RAM_WIDTH  write data.
- cfg_done  out  1  one-cycle pulse when a claimed packet ends.
- cfg_err  out  1  sticky out-of-range flag; cleared only by reset.
- cfg_pkt_cnt  out  16  count of claimed packets; wraps at 65535 to 0.

## Operation
Header fields come from the first beat of a packet, with W = C_S_AXIS_DATA_WIDTH:
- mod_id = tdata[W-129:W-132].
- res_id = tdata[W-133:W-136].
- index = tdata[W-137:W-141].
- tdata[W-142:W-144] is reserved and ignored.

A packet is claimed when mod_id == PARSER_ID and res_id == RESOURCE_ID.

The FSM has four states: IDLE, WRITE, FWD, DROP_HDR. All transitions happen only on cycles where tvalid=1.
- IDLE, claimed, tlast=0: load wr_ptr <= index, go to WRITE. The header is not written and not forwarded.
- IDLE, claimed, tlast=1 (header-only packet): stay in IDLE, pulse cfg_done, increment cfg_pkt_cnt, no write.
- IDLE, not claimed: forward the beat. tlast=0 goes to FWD; tlast=1 stays in IDLE.
- WRITE, each beat:
  - If wr_ptr < NUM_ENTRIES: ram_wr_en=1, addr = wr_ptr, data = tdata[PARSE_ACT_RAM_WIDTH-1:0].
  - Otherwise: no write, set cfg_err.
  - Increment wr_ptr, saturating at NUM_ENTRIES; it never wraps back into the table.
  - On tlast: pulse cfg_done, increment cfg_pkt_cnt, go to IDLE.
- FWD: forward every beat; on tlast go to IDLE.
- DROP_HDR: reserved encoding. The FSM never enters it from reset; if reached, return to IDLE.
- Beats with tvalid=0 are ignored in every state and cause no state change.

Reset: the FSM goes to IDLE. On the first cycle after areset deasserts, the next valid beat is treated as a header, even if a packet was mid-flight.

## Timing
- Reset values:
  - All c_m_axis_* = 0.
  - ram_wr_en = 0, ram_wr_addr = 0, ram_wr_data = 0.
  - cfg_done = 0, cfg_err = 0, cfg_pkt_cnt = 0.
  - wr_ptr = 0.
- Forward path: registered, 1-cycle latency. tdata/tuser/tkeep/tlast travel together. c_m_axis_tvalid=0 and tdata=0 on non-forward cycles.
- Write path: registered. ram_wr_en is high for exactly 1 cycle, the cycle after the payload beat is accepted.
- cfg_done and cfg_pkt_cnt update in the cycle after the claimed tlast beat, aligned with the last ram_wr_en.
- Back-to-back packets: a header may arrive the cycle after a tlast with no bubble.
- Sustained throughput: one beat per cycle in every state.

## Test plan
- Claimed burst: a 4-beat packet with W=512, mod_id=1, res_id=2, index=0; beat 1 low 18 bits 0x0ffff, beats 2-3 low bits 0x...eee_0ffff.
  - Expect 3 writes, to addr 0, 1, 2, on consecutive cycles.
  - Expect cfg_done once, cfg_pkt_cnt=1, and no c_m_axis_tvalid.
- Foreign packet: the same packet with mod_id=3.
  - Expect all 4 beats on c_m_axis 1 cycle later, bit-exact, with tlast on beat 4.
  - Expect no ram_wr_en and cfg_pkt_cnt unchanged.
- Overrun: index=30 with 4 payload beats, NUM_ENTRIES=32.
  - Expect writes to addr 30 and 31 only, cfg_err=1 after the third payload beat, and cfg_done on tlast.
- Header-only claimed packet (tlast on beat 0).
  - Expect no write, a cfg_done pulse, and cfg_pkt_cnt incremented.
- Back-to-back: a claimed packet immediately followed by a foreign packet, with tvalid gaps inserted mid-packet.
  - Expect correct writes, then correct forwarding, with gaps causing no writes and no state change.
- Repeat 20 claimed packets, then assert areset mid-packet.
  - Expect cfg_pkt_cnt=20 before the reset and all outputs zero after it.
  - Expect the next valid beat to be decoded as a header.
